dram_cmd_scheduler: RTL and testbench
=====================================

// Module: dram_cmd_scheduler
// PURPOSE
//  Sits between the trace parser and the DDR4 command output.
//  Buffers parsed memory requests (READ/WRITE/IFETCH) in a FCFS queue.
//  Maps each address to bank group/bank/row/column and sequences DRAM
//  commands PRE/ACT/RD/WR under an open-page policy.
//  Enforces tRP, tRCD, tRAS and tCL+tBURST between commands.
// PARAMETERS
//  QUEUE_DEPTH   16  request queue entries (power of 2)
//  T_RCD         24  ACT -> RD/WR minimum, cycles
//  T_RP          24  PRE -> ACT minimum, cycles
//  T_RAS         52  ACT -> PRE minimum, same bank, cycles
//  T_CL          24  RD/WR issue -> data start, cycles
//  T_BURST        4  data burst length, cycles
// PORTS
//  clk        in   1   clock
//  rst        in   1   async reset, active-high
//  req_valid  in   1   parser presents a request this cycle
//  req_op     in   parsed_op_t  READ, WRITE or IFETCH (NOP ignored)
//  req_addr   in   ADDRESS_WIDTH(33)  byte address
//  req_ready  out  1   queue can accept; high iff queue not full
//  cmd        out  dram_cmd_t  DCMD_NOP/ACT/PRE/RD/WR, valid one cycle
//  cmd_bg     out  2   bank group of cmd
//  cmd_bank   out  2   bank of cmd
//  cmd_row    out  15  row (ACT only; 0 otherwise)
//  cmd_col    out  10  column (RD/WR only; 0 otherwise)
//  done       out  1   one-cycle pulse when current request's burst ends
//  q_count    out  $clog2(QUEUE_DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset (async): queue empty, all banks closed, state IDLE, all counters
//   0; cmd=DCMD_NOP, cmd_* = 0, done=0, req_ready=1, q_count=0.
//  Enqueue on req_valid && req_ready && req_op!=NOP. NOP dropped silently.
//  Full: req_ready=0 even if a dequeue occurs the same cycle.
//  Enqueue+dequeue same cycle (not full): both happen; q_count unchanged.
//  Address map: row=[32:18] colhi=[17:10] bank=[9:8] bg=[7:6]
//   colo=[5:3]; col={colhi,colo[2:1]}... col = addr[17:10],addr[5:4].
//  IFETCH is handled exactly as READ (issues RD).
//  FSM states: IDLE, PRECHARGE, ACTIVATE, ISSUE, WAIT_DATA.
//   IDLE: queue non-empty -> classify head against bank's open row:
//    hit -> ISSUE; bank closed -> ACTIVATE; conflict -> PRECHARGE.
//   PRECHARGE: wait until bank tRAS counter expired, emit PRE once,
//    mark bank closed, count T_RP cycles -> ACTIVATE.
//   ACTIVATE: emit ACT, record open row, load bank tRAS=T_RAS,
//    count T_RCD cycles -> ISSUE.
//   ISSUE: emit RD or WR, pop head, count T_CL+T_BURST -> WAIT_DATA.
//   WAIT_DATA: when count hits 0 pulse done, -> IDLE.
//  Latency (empty queue, banks closed): req accepted cycle N; ACT N+1;
//   RD N+1+T_RCD; done N+1+T_RCD+T_CL+T_BURST.
//  Row hit latency: RD at N+1, done N+1+T_CL+T_BURST.
//  At most one non-NOP cmd per cycle; no command while any wait count > 0.
//  Per-bank tRAS counters (16) decrement every cycle, saturate at 0.
//  Head is popped only at RD/WR issue, never at ACT/PRE.
//  Reset mid-operation: abandons current request; banks forced closed.
// STRUCTURE
//  global_defs additions: dram_cmd_t enum, sched_states_t enum, DRAM
//   timing constants, address-field bit positions, request struct
//   {parsed_op_t op; logic [ADDRESS_WIDTH-1:0] addr;}.
//  Sub-module: req_fifo (parametrised sync FIFO, DEPTH, struct payload,
//   full/empty/count). Bank state table and FSM live in top module.
// TESTING
//  1 Reset then READ 0x0_0000_0000 -> ACT bg0 b0 row0 at +1, RD at
//    +25, done at +53.
//  2 Two READs same row/bank (0x000000000, 0x000000400) -> single ACT;
//    second RD issued 1 cycle after first done, no PRE.
//  3 READ row0 then WRITE row1 same bank (0x000040000) -> PRE not before
//    ACT+52, ACT T_RP later, WR T_RCD after that.
//  4 Push 17 requests back-to-back with no drain -> req_ready drops
//    after 16th, q_count=16, 17th held until first RD pops.
//  5 req_valid with NOP -> nothing enqueued, q_count stays 0, cmd NOP.
//  6 Assert rst during WAIT_DATA -> outputs reset values same cycle;
//    next READ to previously open row issues ACT (banks closed).

Source files
------------

// File: rtl/dram_cmd_scheduler_pkg.sv
// Shared types and constants for the DRAM command scheduler: request/command
// encodings, scheduler states, DDR4 timing values (in controller clock cycles)
// and the bit positions used to split a byte address into bank group, bank,
// row and column.
package dram_cmd_scheduler_pkg;

  localparam int ADDRESS_WIDTH = 33;
  localparam int QUEUE_DEPTH   = 16;

  localparam int T_RCD   = 24;
  localparam int T_RP    = 24;
  localparam int T_RAS   = 52;
  localparam int T_CL    = 24;
  localparam int T_BURST = 4;

  localparam int ROW_MSB   = 32;
  localparam int ROW_LSB   = 18;
  localparam int COLHI_MSB = 17;
  localparam int COLHI_LSB = 10;
  localparam int BANK_MSB  = 9;
  localparam int BANK_LSB  = 8;
  localparam int BG_MSB    = 7;
  localparam int BG_LSB    = 6;
  localparam int COLLO_MSB = 5;
  localparam int COLLO_LSB = 4;

  localparam int ROW_W      = ROW_MSB - ROW_LSB + 1;
  localparam int COL_W      = (COLHI_MSB - COLHI_LSB + 1) + (COLLO_MSB - COLLO_LSB + 1);
  localparam int NUM_BANKS  = 16;
  localparam int BANK_IDX_W = 4;

  localparam int WAIT_W = 6;
  localparam int TRAS_W = 6;

  // Wait counters are loaded with T-1: the command cycle itself is the first
  // cycle of the interval, so the follow-on command lands exactly T later.
  localparam logic [WAIT_W-1:0] RP_WAIT   = WAIT_W'(T_RP - 1);
  localparam logic [WAIT_W-1:0] RCD_WAIT  = WAIT_W'(T_RCD - 1);
  localparam logic [WAIT_W-1:0] DATA_WAIT = WAIT_W'(T_CL + T_BURST - 1);
  localparam logic [TRAS_W-1:0] RAS_LOAD  = TRAS_W'(T_RAS - 1);

  typedef enum logic [1:0] {
    NOP    = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    IFETCH = 2'd3
  } parsed_op_t;

  typedef enum logic [2:0] {
    DCMD_NOP = 3'd0,
    DCMD_ACT = 3'd1,
    DCMD_PRE = 3'd2,
    DCMD_RD  = 3'd3,
    DCMD_WR  = 3'd4
  } dram_cmd_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRECHARGE = 3'd1,
    ACTIVATE  = 3'd2,
    ISSUE     = 3'd3,
    WAIT_DATA = 3'd4
  } sched_states_t;

  typedef struct packed {
    parsed_op_t                op;
    logic [ADDRESS_WIDTH-1:0]  addr;
  } req_t;

endpackage

// File: rtl/dram_cmd_scheduler_fifo.sv
// req_fifo: synchronous FCFS request queue, power-of-two DEPTH.
//   clk_i/rst_i : clock, async active-high reset (empties the queue)
//   push_i      : write data_i (ignored when full)
//   pop_i       : drop head (ignored when empty)
//   head_o      : oldest entry, valid while !empty_o
//   full_o, empty_o, count_o : occupancy status
module req_fifo
  import dram_cmd_scheduler_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  req_t        data_i,
  input  logic        pop_i,
  output req_t        head_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);

  req_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler: queues parsed memory requests and turns the head request
// into DDR4 PRE/ACT/RD/WR commands under an open-page policy, honouring
// tRP, tRCD, tRAS and tCL+tBURST.
//   clk_i, rst_i       : clock, async active-high reset
//   req_valid_i/op/addr: incoming request (NOP ops are dropped)
//   req_ready_o        : queue not full
//   cmd_o + cmd_*_o    : command for this cycle (fields zero when unused)
//   done_o             : one-cycle pulse at end of a request's data burst
//   q_count_o          : queue occupancy
//
// state     | meaning
// IDLE      | queue empty, waiting for a request
// PRECHARGE | row conflict: wait tRAS, send PRE, then wait tRP
// ACTIVATE  | send ACT for head row, then wait tRCD
// ISSUE     | send RD/WR, pop head
// WAIT_DATA | wait tCL+tBURST, pulse done, classify next head
module dram_cmd_scheduler
  import dram_cmd_scheduler_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  input  parsed_op_t                   req_op_i,
  input  logic [ADDRESS_WIDTH-1:0]     req_addr_i,
  output logic                         req_ready_o,
  output dram_cmd_t                    cmd_o,
  output logic [1:0]                   cmd_bg_o,
  output logic [1:0]                   cmd_bank_o,
  output logic [ROW_W-1:0]             cmd_row_o,
  output logic [COL_W-1:0]             cmd_col_o,
  output logic                         done_o,
  output logic [$clog2(QUEUE_DEPTH):0] q_count_o
);

  req_t                  push_data, head;
  logic                  push, pop, fifo_full, fifo_empty;
  logic [ROW_W-1:0]      head_row;
  logic [COL_W-1:0]      head_col;
  logic [1:0]            head_bg, head_bank;
  logic [BANK_IDX_W-1:0] head_idx;
  logic                  unused_addr_lsbs;

  sched_states_t         state_q, state_d, cls_state;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  sent_q, sent_d;
  logic                  bank_act, bank_pre;

  logic                  open_q [NUM_BANKS];
  logic [ROW_W-1:0]      row_q  [NUM_BANKS];
  logic [TRAS_W-1:0]     tras_q [NUM_BANKS];

  assign push_data = '{op: req_op_i, addr: req_addr_i};
  assign push      = req_valid_i && (req_op_i != NOP) && !fifo_full;

  req_fifo #(.DEPTH(QUEUE_DEPTH)) u_req_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (q_count_o)
  );

  assign req_ready_o = !fifo_full;

  assign head_row  = head.addr[ROW_MSB:ROW_LSB];
  assign head_col  = {head.addr[COLHI_MSB:COLHI_LSB], head.addr[COLLO_MSB:COLLO_LSB]};
  assign head_bg   = head.addr[BG_MSB:BG_LSB];
  assign head_bank = head.addr[BANK_MSB:BANK_LSB];
  assign head_idx  = {head_bg, head_bank};
  assign unused_addr_lsbs = ^head.addr[3:0];

  // Where the head request has to start, given the open-row table.
  always_comb begin
    cls_state = IDLE;
    if (!fifo_empty) begin
      if (!open_q[head_idx])                 cls_state = ACTIVATE;
      else if (row_q[head_idx] == head_row)  cls_state = ISSUE;
      else                                   cls_state = PRECHARGE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wait_q  <= '0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      sent_q  <= sent_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    sent_d     = sent_q;
    cmd_o      = DCMD_NOP;
    cmd_bg_o   = '0;
    cmd_bank_o = '0;
    cmd_row_o  = '0;
    cmd_col_o  = '0;
    done_o     = 1'b0;
    pop        = 1'b0;
    bank_act   = 1'b0;
    bank_pre   = 1'b0;
    unique case (state_q)
      IDLE: state_d = cls_state;
      PRECHARGE: begin
        if (!sent_q) begin
          if (tras_q[head_idx] == '0) begin
            cmd_o      = DCMD_PRE;
            cmd_bg_o   = head_bg;
            cmd_bank_o = head_bank;
            bank_pre   = 1'b1;
            wait_d     = RP_WAIT;
            sent_d     = 1'b1;
          end
        end else if (wait_q > WAIT_W'(1)) begin
          wait_d = wait_q - 1'b1;
        end else begin
          wait_d  = '0;
          sent_d  = 1'b0;
          state_d = ACTIVATE;
        end
      end
      ACTIVATE: begin
        if (!sent_q) begin
          cmd_o      = DCMD_ACT;
          cmd_bg_o   = head_bg;
          cmd_bank_o = head_bank;
          cmd_row_o  = head_row;
          bank_act   = 1'b1;
          wait_d     = RCD_WAIT;
          sent_d     = 1'b1;
        end else if (wait_q > WAIT_W'(1)) begin
          wait_d = wait_q - 1'b1;
        end else begin
          wait_d  = '0;
          sent_d  = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cmd_o      = (head.op == WRITE) ? DCMD_WR : DCMD_RD;
        cmd_bg_o   = head_bg;
        cmd_bank_o = head_bank;
        cmd_col_o  = head_col;
        pop        = 1'b1;
        wait_d     = DATA_WAIT;
        state_d    = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (wait_q == '0) begin
          done_o  = 1'b1;
          // Skipping a pass through IDLE lets a queued row hit issue RD on
          // the cycle right after done.
          state_d = cls_state;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        open_q[i] <= 1'b0;
        row_q[i]  <= '0;
        tras_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (tras_q[i] != '0) tras_q[i] <= tras_q[i] - 1'b1;
      end
      if (bank_act) begin
        open_q[head_idx] <= 1'b1;
        row_q[head_idx]  <= head_row;
        tras_q[head_idx] <= RAS_LOAD;
      end
      if (bank_pre) open_q[head_idx] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
module tb_dram_cmd_scheduler;
  import dram_cmd_scheduler_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  parsed_op_t   req_op = NOP;
  logic [32:0]  req_addr = '0;
  logic         req_ready;
  dram_cmd_t    cmd;
  logic [1:0]   cmd_bg, cmd_bank;
  logic [14:0]  cmd_row;
  logic [9:0]   cmd_col;
  logic         done;
  logic [4:0]   q_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    dram_cmd_t   cmd;
    logic [1:0]  bg;
    logic [1:0]  bk;
    logic [14:0] row;
    logic [9:0]  col;
  } ev_t;

  typedef struct {
    parsed_op_t  op;
    logic [32:0] addr;
    int          acc;
  } treq_t;

  ev_t   act_q[$], exp_q[$];
  int    act_done[$], exp_done[$];
  treq_t sent_q[$];

  logic        m_open [16];
  logic [14:0] m_row [16];
  int          m_last_act [16];
  int          m_prev_done;

  dram_cmd_scheduler dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_op_i    (req_op),
    .req_addr_i  (req_addr),
    .req_ready_o (req_ready),
    .cmd_o       (cmd),
    .cmd_bg_o    (cmd_bg),
    .cmd_bank_o  (cmd_bank),
    .cmd_row_o   (cmd_row),
    .cmd_col_o   (cmd_col),
    .done_o      (done),
    .q_count_o   (q_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd != DCMD_NOP) act_q.push_back('{cyc, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col});
      if (done) act_done.push_back(cyc);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_open[i] = 1'b0;
      m_row[i] = '0;
      m_last_act[i] = -1000;
    end
    m_prev_done = -1000;
    sent_q.delete();
  endtask

  task automatic clear_logs();
    act_q.delete();
    exp_q.delete();
    act_done.delete();
    exp_done.delete();
  endtask

  // Timing from the protocol rules: a request is looked at once it is queued
  // and the previous burst has ended; hit -> RD next cycle, closed -> ACT then
  // RD tRCD later, conflict -> PRE (no earlier than tRAS after that bank's ACT),
  // ACT tRP later, RD tRCD after that; done tCL+tBURST after RD/WR.
  task automatic model_build();
    while (sent_q.size() > 0) begin
      treq_t r;
      logic [32:0] a;
      logic [14:0] row;
      logic [9:0] col;
      logic [1:0] bg, bk;
      int b, t, act, pre, rd;
      r = sent_q.pop_front();
      a = r.addr;
      row = a[32:18];
      col = {a[17:10], a[5:4]};
      bg = a[7:6];
      bk = a[9:8];
      b = int'({bg, bk});
      t = (r.acc > m_prev_done) ? r.acc : m_prev_done;
      if (m_open[b] && m_row[b] == row) begin
        rd = t + 1;
      end else begin
        if (m_open[b]) begin
          pre = t + 1;
          if (m_last_act[b] + T_RAS > pre) pre = m_last_act[b] + T_RAS;
          exp_q.push_back('{pre, DCMD_PRE, bg, bk, 15'd0, 10'd0});
          act = pre + T_RP;
        end else begin
          act = t + 1;
        end
        exp_q.push_back('{act, DCMD_ACT, bg, bk, row, 10'd0});
        m_open[b] = 1'b1;
        m_row[b] = row;
        m_last_act[b] = act;
        rd = act + T_RCD;
      end
      exp_q.push_back('{rd, (r.op == WRITE) ? DCMD_WR : DCMD_RD, bg, bk, 15'd0, col});
      m_prev_done = rd + T_CL + T_BURST;
      exp_done.push_back(m_prev_done);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_logs();
  endtask

  task automatic send_req(input parsed_op_t op, input logic [32:0] addr);
    int guard;
    guard = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_addr = addr;
    if (op != NOP) begin
      while (!req_ready && guard < 400) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 400) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: req_ready=%0d required 1", req_ready);
      end else begin
        sent_q.push_back('{op, addr, cyc + 1});
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  function automatic logic [32:0] rand_addr();
    logic [32:0] a;
    a = '0;
    a[32:18] = 15'($urandom_range(0, 2));
    a[17:10] = 8'($urandom);
    a[9:8]   = 2'($urandom_range(0, 1));
    a[7:6]   = 2'($urandom_range(0, 1));
    a[5:3]   = 3'($urandom);
    return a;
  endfunction

  task automatic finish_and_check(input string name);
    int guard;
    int n;
    @(negedge clk);
    req_valid = 1'b0;
    model_build();
    guard = 0;
    while (act_done.size() < exp_done.size() && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (act_done.size() != exp_done.size()) begin
      errors++;
      $display("FAIL %s done_count: got %0d required %0d", name, act_done.size(), exp_done.size());
    end
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s cmd_count: got %0d required %0d", name, act_q.size(), exp_q.size());
    end
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (act_q[i].cyc !== exp_q[i].cyc || act_q[i].cmd !== exp_q[i].cmd ||
          act_q[i].bg !== exp_q[i].bg || act_q[i].bk !== exp_q[i].bk ||
          act_q[i].row !== exp_q[i].row || act_q[i].col !== exp_q[i].col) begin
        errors++;
        $display("FAIL %s cmd%0d: got cyc=%0d %s bg=%0d bk=%0d row=%0d col=%0d required cyc=%0d %s bg=%0d bk=%0d row=%0d col=%0d",
                 name, i, act_q[i].cyc, act_q[i].cmd.name(), act_q[i].bg, act_q[i].bk, act_q[i].row, act_q[i].col,
                 exp_q[i].cyc, exp_q[i].cmd.name(), exp_q[i].bg, exp_q[i].bk, exp_q[i].row, exp_q[i].col);
      end
    end
    n = (act_done.size() < exp_done.size()) ? act_done.size() : exp_done.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (act_done[i] !== exp_done[i]) begin
        errors++;
        $display("FAIL %s done%0d: got cyc=%0d required cyc=%0d", name, i, act_done[i], exp_done[i]);
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (cmd !== DCMD_NOP || cmd_bg !== 2'd0 || cmd_bank !== 2'd0 || cmd_row !== 15'd0 ||
        cmd_col !== 10'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s cmd_outputs: got cmd=%s bg=%0d bk=%0d row=%0d col=%0d done=%0d required all zero/NOP",
               name, cmd.name(), cmd_bg, cmd_bank, cmd_row, cmd_col, done);
    end
    checks++;
    if (req_ready !== 1'b1 || q_count !== 5'd0) begin
      errors++;
      $display("FAIL %s queue_status: got ready=%0d q_count=%0d required ready=1 q_count=0", name, req_ready, q_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    model_reset();
    clear_logs();
    @(negedge clk);
    check_idle_outputs("after_reset");
  endtask

  task automatic test_single_read();
    int acc;
    do_reset();
    send_req(READ, 33'h0);
    acc = sent_q[0].acc;
    finish_and_check("single_read");
    checks++;
    if (act_q.size() < 2 || act_done.size() < 1) begin
      errors++;
      $display("FAIL single_read_latency: got cmds=%0d dones=%0d required 2 and 1", act_q.size(), act_done.size());
    end else if (act_q[0].cmd !== DCMD_ACT || act_q[0].cyc - acc !== 1 ||
                 act_q[1].cyc - acc !== 25 || act_done[0] - acc !== 53) begin
      errors++;
      $display("FAIL single_read_latency: got %s@+%0d rd@+%0d done@+%0d required ACT@+1 rd@+25 done@+53",
               act_q[0].cmd.name(), act_q[0].cyc - acc, act_q[1].cyc - acc, act_done[0] - acc);
    end
  endtask

  task automatic test_row_hit();
    int n_act, n_pre;
    do_reset();
    send_req(READ, 33'h0);
    send_req(READ, 33'h400);
    finish_and_check("row_hit");
    n_act = 0;
    n_pre = 0;
    foreach (act_q[i]) begin
      if (act_q[i].cmd == DCMD_ACT) n_act++;
      if (act_q[i].cmd == DCMD_PRE) n_pre++;
    end
    checks++;
    if (n_act !== 1 || n_pre !== 0) begin
      errors++;
      $display("FAIL row_hit_cmds: got act=%0d pre=%0d required act=1 pre=0", n_act, n_pre);
    end
    checks++;
    if (act_q.size() != 3 || act_done.size() < 1) begin
      errors++;
      $display("FAIL row_hit_gap: got cmds=%0d required 3", act_q.size());
    end else if (act_q[2].cyc !== act_done[0] + 1) begin
      errors++;
      $display("FAIL row_hit_gap: got rd2=%0d required %0d", act_q[2].cyc, act_done[0] + 1);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    send_req(READ, 33'h0);
    send_req(WRITE, 33'h40000);
    finish_and_check("conflict");
    checks++;
    if (act_q.size() != 5) begin
      errors++;
      $display("FAIL conflict_seq: got cmds=%0d required 5", act_q.size());
    end else begin
      if (act_q[2].cmd !== DCMD_PRE || act_q[2].cyc - act_q[0].cyc < T_RAS) begin
        errors++;
        $display("FAIL conflict_tras: got %s at act+%0d required PRE at >= act+%0d",
                 act_q[2].cmd.name(), act_q[2].cyc - act_q[0].cyc, T_RAS);
      end
      checks++;
      if (act_q[3].cmd !== DCMD_ACT || act_q[3].cyc - act_q[2].cyc !== T_RP) begin
        errors++;
        $display("FAIL conflict_trp: got %s at pre+%0d required ACT at pre+%0d",
                 act_q[3].cmd.name(), act_q[3].cyc - act_q[2].cyc, T_RP);
      end
      checks++;
      if (act_q[4].cmd !== DCMD_WR || act_q[4].cyc - act_q[3].cyc !== T_RCD) begin
        errors++;
        $display("FAIL conflict_trcd: got %s at act+%0d required WR at act+%0d",
                 act_q[4].cmd.name(), act_q[4].cyc - act_q[3].cyc, T_RCD);
      end
    end
  endtask

  task automatic test_back_to_back_full();
    int first_acc, acc17, guard;
    logic [32:0] a;
    do_reset();
    for (int i = 0; i < 16; i++) send_req(parsed_op_t'($urandom_range(1, 3)), rand_addr());
    first_acc = sent_q[0].acc;
    @(negedge clk);
    checks++;
    if (q_count !== 5'd16 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_status: got q_count=%0d ready=%0d required 16 and 0", q_count, req_ready);
    end
    a = rand_addr();
    req_valid = 1'b1;
    req_op = READ;
    req_addr = a;
    guard = 0;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    acc17 = cyc + 1;
    sent_q.push_back('{READ, a, acc17});
    checks++;
    if (acc17 !== first_acc + 1 + T_RCD + 2) begin
      errors++;
      $display("FAIL full_17th_accept: got +%0d required +%0d", acc17 - first_acc, 1 + T_RCD + 2);
    end
    finish_and_check("back_to_back_full");
  endtask

  task automatic test_nop();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (q_count !== 5'd0 || cmd !== DCMD_NOP) begin
          errors++;
          $display("FAIL nop_drop: got q_count=%0d cmd=%s required 0 and DCMD_NOP", q_count, cmd.name());
        end
      end
      req_valid = 1'b1;
      req_op = NOP;
      req_addr = rand_addr();
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      send_req(parsed_op_t'($urandom_range(0, 3)), rand_addr());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 60));
    end
    finish_and_check("random");
  endtask

  task automatic test_reset_mid();
    int guard;
    do_reset();
    send_req(READ, 33'h0);
    send_req(READ, 33'h400);
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (act_q.size() < 2 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_idle_outputs("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_logs();
    send_req(READ, 33'h0);
    finish_and_check("after_reset_mid");
    checks++;
    if (act_q.size() < 1) begin
      errors++;
      $display("FAIL reset_closes_banks: got no command required DCMD_ACT");
    end else if (act_q[0].cmd !== DCMD_ACT) begin
      errors++;
      $display("FAIL reset_closes_banks: got %s required DCMD_ACT", act_q[0].cmd.name());
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_row_hit();
    test_conflict();
    test_back_to_back_full();
    test_nop();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
